// File: rtl/vc_arb_mux.sv
// Virtual-channel arbiter/multiplexer: picks one non-empty VC per cycle
// (fixed priority or round robin), pops it and registers the word downstream.
module vc_arb_mux #(
    parameter int DATA_SIZE = 4,
    parameter int NUM_VC    = 2,
    parameter int SEL_W     = 1,
    parameter int RR_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_VC-1:0]           vc_empty,
    input  logic [NUM_VC*DATA_SIZE-1:0] data_in,
    input  logic                        down_almost_full,
    output logic [NUM_VC-1:0]           pop,
    output logic [DATA_SIZE-1:0]        data_out,
    output logic                        valid_out,
    output logic [SEL_W-1:0]            vc_out,
    output logic [15:0]                 busy_cnt
);

    localparam logic [SEL_W:0]   NUM_VC_W = (SEL_W+1)'(NUM_VC);
    localparam logic [SEL_W-1:0] LAST_VC  = SEL_W'(NUM_VC - 1);

    logic [NUM_VC-1:0]           req;
    logic [2*NUM_VC-1:0]         req_rot;
    logic [SEL_W-1:0]            ptr, start, off, grant, ptr_next;
    logic [SEL_W:0]              sum;
    logic [NUM_VC*DATA_SIZE-1:0] data_shift;
    logic                        go;

    assign req   = ~vc_empty;
    assign start = (RR_MODE != 0) ? ptr : '0;
    // reset gates go so nothing is popped in the cycle reset asserts
    assign go    = (|req) & ~down_almost_full & ~reset;

    // Rotate requests so bit 0 is the search start; lowest set bit wins.
    always_comb begin
        req_rot = {req, req} >> start;
        off     = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (req_rot[k]) off = SEL_W'(k);
        end
        sum   = {1'b0, start} + {1'b0, off};
        grant = (sum >= NUM_VC_W) ? SEL_W'(sum - NUM_VC_W) : sum[SEL_W-1:0];
    end

    assign ptr_next   = (grant == LAST_VC) ? '0 : grant + SEL_W'(1);
    assign data_shift = data_in >> (int'(grant) * DATA_SIZE);

    for (genvar i = 0; i < NUM_VC; i++) begin : g_pop
        assign pop[i] = go && (grant == SEL_W'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            vc_out    <= '0;
            busy_cnt  <= '0;
        end else if (go) begin
            ptr       <= ptr_next;
            data_out  <= data_shift[DATA_SIZE-1:0];
            valid_out <= 1'b1;
            vc_out    <= grant;
            busy_cnt  <= busy_cnt + 16'd1;
        end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
            vc_out    <= '0;
        end
    end

endmodule

// File: tb/tb_vc_arb_mux.sv
// Bench for vc_arb_mux: a 2-VC fixed-priority and a 3-VC round-robin instance,
// checked each cycle against a behavioural model plus directed literal checks.
module tb_vc_arb_mux;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  e2;  logic [7:0]  d2;  logic a2;
    logic [1:0]  pop2; logic [3:0] do2; logic v2; logic [0:0] vc2; logic [15:0] bc2;
    logic [2:0]  e3;  logic [11:0] d3;  logic a3;
    logic [2:0]  pop3; logic [3:0] do3; logic v3; logic [1:0] vc3; logic [15:0] bc3;

    vc_arb_mux #(.DATA_SIZE(4), .NUM_VC(2), .SEL_W(1), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset), .vc_empty(e2), .data_in(d2), .down_almost_full(a2),
        .pop(pop2), .data_out(do2), .valid_out(v2), .vc_out(vc2), .busy_cnt(bc2));

    vc_arb_mux #(.DATA_SIZE(4), .NUM_VC(3), .SEL_W(2), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .vc_empty(e3), .data_in(d3), .down_almost_full(a3),
        .pop(pop3), .data_out(do3), .valid_out(v3), .vc_out(vc3), .busy_cnt(bc3));

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // first requesting VC searching start, start+1, ... mod n; -1 if none
    function automatic int first_req(input int n, input int start, input logic [7:0] empty);
        for (int k = 0; k < n; k++) begin
            if (!empty[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    // model state
    int m_ptr = 0;
    logic [3:0] m_do2 = 0, m_do3 = 0;
    logic m_v2 = 0, m_v3 = 0;
    int m_vc2 = 0, m_vc3 = 0;
    logic [15:0] m_bc2 = 0, m_bc3 = 0;
    int g2c, g3c;

    always_comb begin
        g2c = (reset || a2) ? -1 : first_req(2, 0, {6'h3f, e2});
        g3c = (reset || a3) ? -1 : first_req(3, m_ptr, {5'h1f, e3});
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr <= 0;
            m_do2 <= 0; m_v2 <= 0; m_vc2 <= 0; m_bc2 <= 0;
            m_do3 <= 0; m_v3 <= 0; m_vc3 <= 0; m_bc3 <= 0;
        end else begin
            if (g2c >= 0) begin
                m_do2 <= d2[g2c*4 +: 4]; m_v2 <= 1; m_vc2 <= g2c; m_bc2 <= m_bc2 + 1;
            end else begin
                m_do2 <= 0; m_v2 <= 0; m_vc2 <= 0;
            end
            if (g3c >= 0) begin
                m_do3 <= d3[g3c*4 +: 4]; m_v3 <= 1; m_vc3 <= g3c; m_bc3 <= m_bc3 + 1;
                m_ptr <= (g3c + 1) % 3;
            end else begin
                m_do3 <= 0; m_v3 <= 0; m_vc3 <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pop2", pop2, (g2c < 0) ? 0 : (1 << g2c));
            chk("m_data2", do2, m_do2);
            chk("m_valid2", v2, m_v2);
            chk("m_vc2", vc2, m_vc2);
            chk("m_cnt2", bc2, m_bc2);
            chk("m_pop3", pop3, (g3c < 0) ? 0 : (1 << g3c));
            chk("m_data3", do3, m_do3);
            chk("m_valid3", v3, m_v3);
            chk("m_vc3", vc3, m_vc3);
            chk("m_cnt3", bc3, m_bc3);
        end
    end

    int seq[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        e2 = 2'b11; d2 = 0; a2 = 0;
        e3 = 3'b111; d3 = 0; a3 = 0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", v2, 0); chk("rst_data", do2, 0); chk("rst_cnt", bc2, 0);
        chk("rst_pop", pop2, 0);
        reset = 0;

        // fixed priority: VC1 starved
        e2 = 2'b00; d2 = {4'h5, 4'h3}; #1;
        for (int i = 0; i < 3; i++) begin
            chk("fp_pop", pop2, 2'b01);
            @(posedge clk); #2;
            chk("fp_vc", vc2, 0); chk("fp_data", do2, 4'h3); chk("fp_valid", v2, 1);
        end

        // idle, then a single-cycle VC1 word
        e2 = 2'b11; #1;
        chk("idle_pop", pop2, 0);
        @(posedge clk); #2;
        chk("idle_valid", v2, 0); chk("idle_data", do2, 0);
        e2 = 2'b01; d2 = {4'hC, 4'h0}; #1;
        chk("one_pop", pop2, 2'b10);
        @(posedge clk); #1;
        e2 = 2'b11; #1;
        chk("one_valid", v2, 1); chk("one_data", do2, 4'hC); chk("one_vc", vc2, 1);
        chk("one_pop_after", pop2, 0);
        @(posedge clk); #2;
        chk("one_valid_drop", v2, 0);

        // stall and requests arriving together: stall wins
        a2 = 1; e2 = 2'b00; #1;
        chk("stall_pop", pop2, 0);
        @(posedge clk); #2;
        chk("stall_valid", v2, 0);
        a2 = 0; e2 = 2'b11;

        // round robin, all VCs non-empty
        e3 = 3'b000; d3 = {4'h9, 4'h8, 4'h7}; #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_pop", pop3, 1 << seq[i]);
            @(posedge clk); #2;
            chk("rr_vc", vc3, seq[i]);
        end

        // only VC2: grant 2 every cycle, pointer wraps to 0
        e3 = 3'b011; #1;
        for (int i = 0; i < 3; i++) begin
            chk("rr2_pop", pop3, 3'b100);
            @(posedge clk); #2;
            chk("rr2_vc", vc3, 2); chk("rr2_data", do3, 4'h9);
        end

        // backpressure holds the pointer
        e3 = 3'b000; #1;
        chk("bp_pre_pop", pop3, 3'b001);
        @(posedge clk); #1;
        a3 = 1; #1;
        for (int i = 0; i < 2; i++) begin
            chk("bp_pop", pop3, 0);
            @(posedge clk); #2;
            chk("bp_valid", v3, 0); chk("bp_data", do3, 0);
        end
        a3 = 0; #1;
        chk("bp_resume_pop", pop3, 3'b010);
        @(posedge clk); #2;
        chk("bp_resume_vc", vc3, 1); chk("bp_resume_data", do3, 4'h8);
        e3 = 3'b111;

        // asynchronous reset mid-stream
        e2 = 2'b10; d2 = {4'h0, 4'hA};
        @(posedge clk); #2;
        chk("mid_data_pre", do2, 4'hA);
        reset = 1; #1;
        chk("mid_rst_data", do2, 0); chk("mid_rst_valid", v2, 0);
        chk("mid_rst_cnt", bc2, 0); chk("mid_rst_pop", pop2, 0);
        @(posedge clk); #1;
        reset = 0; #1;
        chk("post_rst_pop", pop2, 2'b01);
        @(posedge clk); #2;
        chk("post_rst_data", do2, 4'hA); chk("post_rst_valid", v2, 1);
        chk("post_rst_cnt", bc2, 1);

        // counter wrap
        reset = 1; #1;
        reset = 0;
        repeat (65535) @(posedge clk);
        #2;
        chk("cnt_full", bc2, 16'hFFFF);
        @(posedge clk); #2;
        chk("cnt_wrap", bc2, 0);

        e2 = 2'b11;
        @(posedge clk); #2;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
